// File: rtl/ysyx_23060061_branch_resolve_unit_if.sv
// rtl/ysyx_23060061_branch_resolve_unit_if.sv - request/result handshake bundle for the branch resolve unit
interface ysyx_23060061_branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;
  logic            out_illegal;

  // master issues branches and consumes results; slave is the resolve unit
  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal
  );
endinterface

// File: rtl/ysyx_23060061_branch_resolve_unit.sv
// rtl/ysyx_23060061_branch_resolve_unit.sv - registered branch resolution with mispredict detect and perf counters
module ysyx_23060061_branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  ysyx_23060061_branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]              cnt_branches,
  output logic [CNT_W-1:0]              cnt_mispredict
);

  logic            isEq;
  logic            isLt;
  logic            isLtu;
  logic            condTaken;
  logic            condIllegal;
  logic [XLEN-1:0] takenTarget;
  logic [XLEN-1:0] seqTarget;
  logic [XLEN-1:0] nextTarget;
  logic            condMispredict;
  logic            accept;
  logic            consume;

  assign isEq  = (bus.in_rs1 == bus.in_rs2);
  assign isLt  = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
  assign isLtu = (bus.in_rs1 < bus.in_rs2);

  always_comb begin
    condTaken   = 1'b0;
    condIllegal = 1'b0;
    case (bus.in_funct3)
      3'b000:  condTaken = isEq;
      3'b001:  condTaken = !isEq;
      3'b100:  condTaken = isLt;
      3'b101:  condTaken = !isLt;
      3'b110:  condTaken = isLtu;
      3'b111:  condTaken = !isLtu;
      default: condIllegal = 1'b1;
    endcase
  end

  assign takenTarget = bus.in_pc + bus.in_imm;
  assign seqTarget   = bus.in_pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign nextTarget  = condTaken ? takenTarget : seqTarget;

  // an illegal funct3 resolves not-taken, so it only redirects if predicted taken
  assign condMispredict = (condTaken != bus.in_pred_taken) ||
                          (condTaken && bus.in_pred_taken && (bus.in_pred_target != takenTarget));

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign consume      = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_taken      <= 1'b0;
      bus.out_target     <= '0;
      bus.out_mispredict <= 1'b0;
      bus.out_illegal    <= 1'b0;
    end else if (accept) begin
      bus.out_valid      <= 1'b1;
      bus.out_taken      <= condTaken;
      bus.out_target     <= nextTarget;
      bus.out_mispredict <= condMispredict;
      bus.out_illegal    <= condIllegal;
    end else if (consume || flush) begin
      bus.out_valid      <= 1'b0;
    end
  end

  // a handshake coincident with flush still retires, so counting follows consume only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branches   <= '0;
      cnt_mispredict <= '0;
    end else if (consume) begin
      if (cnt_branches != '1) begin
        cnt_branches <= cnt_branches + CNT_W'(1);
      end
      if (bus.out_mispredict && (cnt_mispredict != '1)) begin
        cnt_mispredict <= cnt_mispredict + CNT_W'(1);
      end
    end
  end

endmodule
